serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a, b and borrow-in on start, then resolves one
// difference bit per clock (LSB first) and publishes diff/bout together on completion.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_bit;
   logic             br_next;

   // One full-subtractor cell, fed by the LSBs of the operand shift registers.
   assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
   assign br_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

   // NOTE: every signal gets a hold default before the case so no path leaves one
   // unassigned; otherwise synthesis would infer a latch to remember the old value.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d  = {d_bit, res_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            cnt_d  = cnt_q + CW'(1);
            // The last bit is folded straight into diff so it never shows a partial word.
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = br_next;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the values from
   // before the edge; blocking here would create ordering-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule
